// File: rtl/rr_decoder_grant_scheduler.sv
// Round-robin owner selection for a shared 3-to-8 decoded select resource.
// Presents a registered one-hot grant plus its index; holds it until release or hold timeout.
module rr_decoder_grant_scheduler #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned TW = $clog2(HOLD_MAX + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [TW-1:0] tmr;

    logic [2:0]    winner;
    logic [2:0]    cand;
    logic          found;
    logic          owner_release;
    logic          hold_expired;

    function automatic logic [7:0] decode(input logic [2:0] idx);
        decode = 8'b0000_0001 << idx;
    endfunction

    // First set request scanning upward from ptr, wrapping modulo 8.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_release = done || !req[gnt_idx];
        hold_expired  = (tmr == TMR_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            tmr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt_idx   <= winner;
                        gnt       <= decode(winner);
                        gnt_valid <= 1'b1;
                        tmr       <= '0;
                    end
                end
                GRANT: begin
                    if (owner_release || hold_expired) begin
                        // An owner release takes precedence over a coincident expiry.
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= !owner_release;
                        ptr       <= gnt_idx + 3'd1;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                RELEASE: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    timeout   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_decoder_grant_scheduler.sv
// Randomized scoreboard bench: a transaction-level model predicts each grant (owner, start edge,
// length, timeout) and a monitor reconstructs grants from the DUT outputs and compares.
module tb_rr_decoder_grant_scheduler;

    localparam int unsigned HM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_decoder_grant_scheduler #(.HOLD_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int start;
        int len;
        int to;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: current owner (-1 = none), cycles it has held the grant,
    // blanking cycles still to pass before arbitration resumes, and the priority start.
    int m_owner = -1;
    int m_held  = 0;
    int m_start = 0;
    int m_cool  = 0;
    int m_ptr   = 0;
    int m_edges = 0;

    // Monitor state
    int   mon_edges = 0;
    bit   mon_open  = 1'b0;
    txn_t cur;
    int   last_idx  = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic s_rst, input logic [7:0] r, input logic d);
        txn_t t;
        m_edges++;
        if (s_rst) begin
            m_owner = -1;
            m_cool  = 0;
            m_ptr   = 0;
            return;
        end
        if (m_owner >= 0) begin
            if (d || !r[m_owner] || m_held == int'(HM)) begin
                t.idx   = m_owner;
                t.start = m_start;
                t.len   = m_held;
                t.to    = (d || !r[m_owner]) ? 0 : 1;
                exp_q.push_back(t);
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (m_owner < 0 && r[c]) m_owner = c;
            end
            m_start = m_edges;
            m_held  = 1;
        end
    endtask

    // Monitor: samples 1 time unit after every rising edge.
    initial begin
        logic [7:0] dec;
        txn_t e;
        forever begin
            @(posedge clk);
            #1;
            mon_edges++;
            if (rst) begin
                mon_open = 1'b0;
                last_idx = 0;
                check("reset_gnt", int'(gnt), 0);
                check("reset_gnt_idx", int'(gnt_idx), 0);
                check("reset_gnt_valid", int'(gnt_valid), 0);
                check("reset_timeout", int'(timeout), 0);
            end else begin
                dec = 8'h01 << gnt_idx;
                check("gnt_shape", int'(gnt), gnt_valid ? int'(dec) : 0);
                if (gnt_valid) begin
                    check("timeout_while_granted", int'(timeout), 0);
                    if (!mon_open) begin
                        mon_open  = 1'b1;
                        cur.idx   = int'(gnt_idx);
                        cur.start = mon_edges;
                        cur.len   = 1;
                    end else begin
                        cur.len++;
                        check("idx_stable", int'(gnt_idx), cur.idx);
                    end
                end else begin
                    check("idx_hold", int'(gnt_idx), last_idx);
                    if (mon_open) begin
                        mon_open = 1'b0;
                        check("hold_limit", (cur.len <= int'(HM)) ? 1 : 0, 1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_grant", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("grant_idx", cur.idx, e.idx);
                            check("grant_start", cur.start, e.start);
                            check("grant_len", cur.len, e.len);
                            check("grant_timeout", int'(timeout), e.to);
                        end
                    end else begin
                        check("stray_timeout", int'(timeout), 0);
                    end
                end
                last_idx = int'(gnt_idx);
            end
        end
    end

    // Driver: inputs change on the falling edge; the model consumes them at the rising edge.
    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        for (int i = 0; i < 1430; i++) begin
            @(posedge clk);
            model_step(rst, req, done);
            @(negedge clk);
            rst  = 1'b0;
            done = 1'b0;
            if (i < 3) begin
                rst = 1'b1;
                req = 8'h00;
            end else if (i < 60) begin
                req  = 8'hFF;
                done = 1'b1;
                rst  = (i == 30);
            end else if (i < 100) begin
                req = 8'h04;
            end else if (i < 200) begin
                req  = 8'h04;
                done = ($urandom_range(0, 2) == 0);
            end else if (i < 260) begin
                req  = 8'h20;
                done = ($urandom_range(0, 2) == 0);
            end else if (i < 320) begin
                req  = {1'b0, 1'b1, 5'b0, ($urandom_range(0, 3) != 0)};
                done = ($urandom_range(0, 3) == 0);
            end else if (i < 1400) begin
                req  = $urandom_range(0, 1) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
                done = ($urandom_range(0, 3) == 0);
                rst  = ($urandom_range(0, 59) == 0);
            end else begin
                req = 8'h00;
            end
            if (rst) begin
                #1;
                check("async_reset_gnt", int'(gnt), 0);
                check("async_reset_gnt_idx", int'(gnt_idx), 0);
                check("async_reset_gnt_valid", int'(gnt_valid), 0);
                check("async_reset_timeout", int'(timeout), 0);
            end
        end
        check("queue_drained", exp_q.size(), 0);
        check("no_open_grant", int'(mon_open), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
